// File: rtl/dsp_mult_checker.sv
// Response checker for the dsp_t1 multiplier: rebuilds the reference product, aligns it to DSP latency, counts matches/mismatches.
// Optional first-mismatch capture ports are enabled by defining DSP_CHK_FIRST_ERR_EN.
module dsp_mult_checker #(
  parameter int A_WIDTH   = 20,
  parameter int B_WIDTH   = 18,
  parameter int Z_WIDTH   = 38,
  parameter int LATENCY   = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 valid_i,
  input  logic [A_WIDTH-1:0]   a_i,
  input  logic [B_WIDTH-1:0]   b_i,
  input  logic                 unsigned_a_i,
  input  logic                 unsigned_b_i,
  input  logic [Z_WIDTH-1:0]   z_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fail_o,
  output logic [CNT_WIDTH-1:0] chk_count_o,
  output logic [CNT_WIDTH-1:0] err_count_o
`ifdef DSP_CHK_FIRST_ERR_EN
  ,
  output logic [Z_WIDTH-1:0]   first_err_exp_o,
  output logic [Z_WIDTH-1:0]   first_err_got_o,
  output logic [CNT_WIDTH-1:0] first_err_idx_o
`endif
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [P_WIDTH-1:0]   a_ext, b_ext;
  logic [Z_WIDTH-1:0]   exp_val;
  logic [Z_WIDTH-1:0]   exp_pipe [LATENCY];
  logic [LATENCY-1:0]   vld_pipe;
  logic                 cmp_vld, cmp_err, drain_empty;
  logic [CNT_WIDTH-1:0] chk_q, err_q, chk_next;
  logic                 fail_q;

  // Extension to full product width keeps the truncated product exact for every sign mix
  assign a_ext   = {{B_WIDTH{a_i[A_WIDTH-1] & ~unsigned_a_i}}, a_i};
  assign b_ext   = {{A_WIDTH{b_i[B_WIDTH-1] & ~unsigned_b_i}}, b_i};
  assign exp_val = Z_WIDTH'(a_ext * b_ext);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vld_pipe <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) exp_pipe[i] <= '0;
    end else if (start_i) begin
      vld_pipe <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) exp_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= valid_i && (state_q == S_RUN);
      exp_pipe[0] <= exp_val;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
      end
    end
  end

  assign cmp_vld = vld_pipe[LATENCY-1];
  assign cmp_err = cmp_vld && (z_i !== exp_pipe[LATENCY-1]);

  // The last stage empties on this edge, so only the earlier stages decide when draining ends
  always_comb begin
    drain_empty = 1'b1;
    for (int unsigned i = 0; i + 1 < LATENCY; i++) begin
      if (vld_pipe[i]) drain_empty = 1'b0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_RUN:   if (stop_i) state_d = S_DRAIN;
        S_DRAIN: if (drain_empty) state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign chk_next = (chk_q != '1) ? chk_q + CNT_WIDTH'(1) : chk_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      chk_q  <= '0;
      err_q  <= '0;
      fail_q <= 1'b0;
    end else if (start_i) begin
      chk_q  <= '0;
      err_q  <= '0;
      fail_q <= 1'b0;
    end else if (cmp_vld) begin
      chk_q <= chk_next;
      if (cmp_err) begin
        fail_q <= 1'b1;
        if (err_q != '1) err_q <= err_q + CNT_WIDTH'(1);
      end
    end
  end

  assign busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);
  assign fail_o      = fail_q;
  assign chk_count_o = chk_q;
  assign err_count_o = err_q;

`ifdef DSP_CHK_FIRST_ERR_EN
  // fail_q still clear on the compare edge marks the first mismatch of the run
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      first_err_exp_o <= '0;
      first_err_got_o <= '0;
      first_err_idx_o <= '0;
    end else if (start_i) begin
      first_err_exp_o <= '0;
      first_err_got_o <= '0;
      first_err_idx_o <= '0;
    end else if (cmp_err && !fail_q) begin
      first_err_exp_o <= exp_pipe[LATENCY-1];
      first_err_got_o <= z_i;
      first_err_idx_o <= chk_next;
    end
  end
`else
  // No first-mismatch capture in this build.
`endif

endmodule

// File: tb/tb_dsp_mult_checker.sv
// Directed bench for dsp_mult_checker: three instances (latency 1, latency 2, 4-bit counters) share one operand stream.
module tb_dsp_mult_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, valid = 1'b0;
  logic [19:0] a = '0;
  logic [17:0] b = '0;
  logic        ua = 1'b0, ub = 1'b0;
  logic [37:0] z_l1 = '0, z_l2 = '0, z_sat = '0;

  logic        busy_l1, done_l1, fail_l1;
  logic        busy_l2, done_l2, fail_l2;
  logic        busy_sat, done_sat, fail_sat;
  logic [15:0] chk_l1, err_l1, chk_l2, err_l2;
  logic [3:0]  chk_sat, err_sat;

  int errors = 0;
  int checks = 0;

  logic [19:0] va   [0:31];
  logic [17:0] vb   [0:31];
  logic        ua_v [0:31];
  logic        ub_v [0:31];
  logic [37:0] vz   [0:31];

  always #5 clk = ~clk;

  dsp_mult_checker #(.A_WIDTH(20), .B_WIDTH(18), .Z_WIDTH(38), .LATENCY(1), .CNT_WIDTH(16)) u_l1 (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start), .stop_i(stop), .valid_i(valid),
    .a_i(a), .b_i(b), .unsigned_a_i(ua), .unsigned_b_i(ub), .z_i(z_l1),
    .busy_o(busy_l1), .done_o(done_l1), .fail_o(fail_l1), .chk_count_o(chk_l1), .err_count_o(err_l1));

  dsp_mult_checker #(.A_WIDTH(20), .B_WIDTH(18), .Z_WIDTH(38), .LATENCY(2), .CNT_WIDTH(16)) u_l2 (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start), .stop_i(stop), .valid_i(valid),
    .a_i(a), .b_i(b), .unsigned_a_i(ua), .unsigned_b_i(ub), .z_i(z_l2),
    .busy_o(busy_l2), .done_o(done_l2), .fail_o(fail_l2), .chk_count_o(chk_l2), .err_count_o(err_l2));

  dsp_mult_checker #(.A_WIDTH(20), .B_WIDTH(18), .Z_WIDTH(38), .LATENCY(1), .CNT_WIDTH(4)) u_sat (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start), .stop_i(stop), .valid_i(valid),
    .a_i(a), .b_i(b), .unsigned_a_i(ua), .unsigned_b_i(ub), .z_i(z_sat),
    .busy_o(busy_sat), .done_o(done_sat), .fail_o(fail_sat), .chk_count_o(chk_sat), .err_count_o(err_sat));

  task automatic set_z(input int sel, input logic [37:0] v);
    case (sel)
      1:       z_l1  = v;
      2:       z_l2  = v;
      default: z_sat = v;
    endcase
  endtask

  // Called at a falling edge; leaves the checkers in RUN at the next falling edge.
  task automatic do_start();
    start = 1'b1; stop = 1'b0; valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams n operand pairs back to back, feeding vz[k] to the selected z input lat cycles later.
  task automatic run_vec(input int n, input int lat, input int sel);
    for (int c = 0; c < n + lat; c++) begin
      if (c < n) begin
        valid = 1'b1; a = va[c]; b = vb[c]; ua = ua_v[c]; ub = ub_v[c];
      end else begin
        valid = 1'b0;
      end
      if (c >= lat) set_z(sel, vz[c-lat]);
      @(negedge clk);
    end
    valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({busy_l1, done_l1, fail_l1} !== 3'b000) begin errors++; $display("FAIL reset_flags_l1 got=%b exp=000", {busy_l1, done_l1, fail_l1}); end
    checks++; if ({chk_l1, err_l1} !== 32'd0) begin errors++; $display("FAIL reset_cnt_l1 got=%0d/%0d exp=0/0", chk_l1, err_l1); end
    checks++; if ({busy_l2, done_l2, fail_l2} !== 3'b000) begin errors++; $display("FAIL reset_flags_l2 got=%b exp=000", {busy_l2, done_l2, fail_l2}); end
    checks++; if ({chk_l2, err_l2} !== 32'd0) begin errors++; $display("FAIL reset_cnt_l2 got=%0d/%0d exp=0/0", chk_l2, err_l2); end
    checks++; if ({busy_sat, done_sat, fail_sat, chk_sat, err_sat} !== 11'd0) begin errors++; $display("FAIL reset_sat got=%b exp=0", {busy_sat, done_sat, fail_sat, chk_sat, err_sat}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({busy_l1, done_l1} !== 2'b00) begin errors++; $display("FAIL idle_after_reset got=%b exp=00", {busy_l1, done_l1}); end
  endtask

  task automatic test_signed_l1();
    do_start();
    checks++; if ({busy_l1, done_l1} !== 2'b10) begin errors++; $display("FAIL start_busy_l1 got=%b exp=10", {busy_l1, done_l1}); end
    va[0] = 20'hFFFFD; vb[0] = 18'd7;       ua_v[0] = 1'b0; ub_v[0] = 1'b0; vz[0] = 38'h3FFFFFFFEB;
    va[1] = 20'h7FFFF; vb[1] = 18'h1FFFF;   ua_v[1] = 1'b0; ub_v[1] = 1'b0; vz[1] = 38'h0FFFF60001;
    run_vec(2, 1, 1);
    checks++; if (chk_l1 !== 16'd2) begin errors++; $display("FAIL signed_chk got=%0d exp=2", chk_l1); end
    checks++; if (err_l1 !== 16'd0) begin errors++; $display("FAIL signed_err got=%0d exp=0", err_l1); end
    checks++; if (fail_l1 !== 1'b0) begin errors++; $display("FAIL signed_fail got=%b exp=0", fail_l1); end
  endtask

  task automatic test_unsigned_flags();
    do_start();
    va[0] = 20'hFFFFF; vb[0] = 18'd2;     ua_v[0] = 1'b1; ub_v[0] = 1'b0; vz[0] = 38'h3FFFFFFFFE;
    va[1] = 20'hFFFFF; vb[1] = 18'd2;     ua_v[1] = 1'b1; ub_v[1] = 1'b0; vz[1] = 38'h00001FFFFE;
    va[2] = 20'hFFFFF; vb[2] = 18'd2;     ua_v[2] = 1'b0; ub_v[2] = 1'b0; vz[2] = 38'h3FFFFFFFFE;
    va[3] = 20'd3;     vb[3] = 18'h3FFFF; ua_v[3] = 1'b0; ub_v[3] = 1'b1; vz[3] = 38'h00000BFFFD;
    run_vec(4, 1, 1);
    checks++; if (chk_l1 !== 16'd4) begin errors++; $display("FAIL unsigned_chk got=%0d exp=4", chk_l1); end
    checks++; if (err_l1 !== 16'd1) begin errors++; $display("FAIL unsigned_err got=%0d exp=1", err_l1); end
    checks++; if (fail_l1 !== 1'b1) begin errors++; $display("FAIL unsigned_fail got=%b exp=1", fail_l1); end
  endtask

  task automatic test_latency2_align();
    for (int i = 0; i < 10; i++) begin
      va[i] = 20'(i + 1); vb[i] = 18'h3FFFB; ua_v[i] = 1'b0; ub_v[i] = 1'b0; vz[i] = 38'(-5 * (i + 1));
    end
    do_start();
    run_vec(10, 2, 2);
    checks++; if (chk_l2 !== 16'd10) begin errors++; $display("FAIL l2_chk got=%0d exp=10", chk_l2); end
    checks++; if (err_l2 !== 16'd0) begin errors++; $display("FAIL l2_err got=%0d exp=0", err_l2); end
    checks++; if (fail_l2 !== 1'b0) begin errors++; $display("FAIL l2_fail got=%b exp=0", fail_l2); end
    do_start();
    run_vec(10, 1, 2);
    checks++; if (chk_l2 !== 16'd10) begin errors++; $display("FAIL l2_early_chk got=%0d exp=10", chk_l2); end
    checks++; if (err_l2 == 16'd0) begin errors++; $display("FAIL l2_early_err got=%0d exp=>0", err_l2); end
    checks++; if (fail_l2 !== 1'b1) begin errors++; $display("FAIL l2_early_fail got=%b exp=1", fail_l2); end
  endtask

  task automatic test_stop_drain();
    do_start();
    ua = 1'b0; ub = 1'b0;
    valid = 1'b1; a = 20'd1; b = 18'd1;               @(negedge clk);
    a = 20'd2;                                        @(negedge clk);
    a = 20'd3; z_l2 = 38'd1;                          @(negedge clk);
    valid = 1'b0; stop = 1'b1; z_l2 = 38'd2;          @(negedge clk);
    checks++; if ({busy_l2, done_l2} !== 2'b10) begin errors++; $display("FAIL drain_state got=%b exp=10", {busy_l2, done_l2}); end
    stop = 1'b0; valid = 1'b1; a = 20'd7; b = 18'd7; z_l2 = 38'd3;
    @(negedge clk);
    checks++; if ({busy_l2, done_l2} !== 2'b01) begin errors++; $display("FAIL drain_done got=%b exp=01", {busy_l2, done_l2}); end
    checks++; if (chk_l2 !== 16'd3) begin errors++; $display("FAIL drain_chk got=%0d exp=3", chk_l2); end
    checks++; if (err_l2 !== 16'd0) begin errors++; $display("FAIL drain_err got=%0d exp=0", err_l2); end
    z_l2 = 38'd5;
    repeat (3) @(negedge clk);
    valid = 1'b0;
    checks++; if ({chk_l2, done_l2} !== {16'd3, 1'b1}) begin errors++; $display("FAIL after_stop got=%0d/%b exp=3/1", chk_l2, done_l2); end
    // Stop with an empty pipeline: one DRAIN cycle, then DONE.
    do_start();
    stop = 1'b1; @(negedge clk);
    stop = 1'b0;
    checks++; if ({busy_l2, done_l2} !== 2'b10) begin errors++; $display("FAIL empty_drain got=%b exp=10", {busy_l2, done_l2}); end
    @(negedge clk);
    checks++; if ({busy_l2, done_l2, chk_l2} !== {2'b01, 16'd0}) begin errors++; $display("FAIL empty_done got=%b/%0d exp=01/0", {busy_l2, done_l2}, chk_l2); end
    // start and stop together: start wins.
    start = 1'b1; stop = 1'b1; @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checks++; if ({busy_l2, done_l2} !== 2'b10) begin errors++; $display("FAIL start_wins got=%b exp=10", {busy_l2, done_l2}); end
    @(negedge clk);
    checks++; if ({busy_l2, done_l2} !== 2'b10) begin errors++; $display("FAIL start_wins_hold got=%b exp=10", {busy_l2, done_l2}); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      va[i] = 20'd1; vb[i] = 18'd1; ua_v[i] = 1'b0; ub_v[i] = 1'b0; vz[i] = 38'd0;
    end
    do_start();
    run_vec(20, 1, 3);
    checks++; if (err_sat !== 4'd15) begin errors++; $display("FAIL sat_err got=%0d exp=15", err_sat); end
    checks++; if (chk_sat !== 4'd15) begin errors++; $display("FAIL sat_chk got=%0d exp=15", chk_sat); end
    checks++; if (fail_sat !== 1'b1) begin errors++; $display("FAIL sat_fail got=%b exp=1", fail_sat); end
    do_start();
    checks++; if ({chk_sat, err_sat, fail_sat} !== 9'd0) begin errors++; $display("FAIL restart_clear got=%0d/%0d/%b exp=0/0/0", chk_sat, err_sat, fail_sat); end
    checks++; if ({busy_sat, done_sat} !== 2'b10) begin errors++; $display("FAIL restart_busy got=%b exp=10", {busy_sat, done_sat}); end
  endtask

  task automatic test_async_reset();
    do_start();
    ua = 1'b0; ub = 1'b0; z_l2 = 38'd0;
    for (int c = 0; c < 4; c++) begin
      valid = 1'b1; a = 20'(c + 1); b = 18'd1;
      @(negedge clk);
    end
    checks++; if ({chk_l2, err_l2} !== {16'd2, 16'd2}) begin errors++; $display("FAIL prereset_cnt got=%0d/%0d exp=2/2", chk_l2, err_l2); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy_l2, done_l2, fail_l2} !== 3'b000) begin errors++; $display("FAIL areset_flags got=%b exp=000", {busy_l2, done_l2, fail_l2}); end
    checks++; if ({chk_l2, err_l2} !== 32'd0) begin errors++; $display("FAIL areset_cnt got=%0d/%0d exp=0/0", chk_l2, err_l2); end
    #3;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    valid = 1'b0;
    checks++; if ({chk_l2, err_l2} !== 32'd0) begin errors++; $display("FAIL postreset_cnt got=%0d/%0d exp=0/0", chk_l2, err_l2); end
    checks++; if ({busy_l2, done_l2, fail_l2} !== 3'b000) begin errors++; $display("FAIL postreset_idle got=%b exp=000", {busy_l2, done_l2, fail_l2}); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_signed_l1();
    test_unsigned_flags();
    test_latency2_align();
    test_stop_drain();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/dsp_mult_checker.md
Name: dsp_mult_checker

Overview:
- Response-side checker for the qlf_k6n10f DSP multiplier (dsp_t1 in multiply mode). Sits at the output end of the DSP on hardware and in benches.
- Takes the same operand stream that is driven into the DSP and computes the reference product internally.
- Delays that product by the DSP's configured latency, compares it against the DSP z output and accumulates pass/fail statistics.
- Replaces testbench-only checking so that DSP self-test can run on silicon.

Parameters:
- A_WIDTH, 20, width of operand A.
- B_WIDTH, 18, width of operand B.
- Z_WIDTH, 38, width of the DSP result; must satisfy Z_WIDTH <= A_WIDTH+B_WIDTH.
- LATENCY, 1, DSP cycles from operand presentation to valid z (1 = registered inputs, 2 = registered inputs plus output register); legal range 1..8.
- CNT_WIDTH, 16, width of the check and error counters.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; clears statistics and begins a run.
- stop_i  in  1  one-cycle pulse; ends the run after the pipeline drains.
- valid_i  in  1  a_i/b_i carry an operand pair this cycle, presented to the DSP in the same cycle.
- a_i  in  A_WIDTH  operand A.
- b_i  in  B_WIDTH  operand B.
- unsigned_a_i  in  1  1 = treat A as unsigned, 0 = signed.
- unsigned_b_i  in  1  1 = treat B as unsigned, 0 = signed.
- z_i  in  Z_WIDTH  DSP result.
- busy_o  out  1  run in progress (RUN or DRAIN).
- done_o  out  1  run complete; held until next start_i.
- fail_o  out  1  sticky; at least one mismatch since start.
- chk_count_o  out  CNT_WIDTH  number of comparisons performed.
- err_count_o  out  CNT_WIDTH  number of mismatches.

Behaviour:
- Reset (async, reset_n_i=0): state IDLE; all outputs 0; expected and valid pipelines cleared.
- States:
  - IDLE: waits for start_i, then goes to RUN.
  - RUN: accepts operands; on stop_i goes to DRAIN.
  - DRAIN: operands ignored; leaves when the valid pipeline is empty, then goes to DONE.
  - DONE: on start_i goes to RUN.
- start_i in any state: clears counters and fail_o, flushes the pipelines, enters RUN the next cycle. done_o drops and busy_o rises in that same cycle.
- start_i and stop_i together: start_i wins.
- Expected value:
  - Each operand is extended to A_WIDTH+B_WIDTH bits, sign- or zero-extended per its unsigned flag.
  - The two are multiplied and the product truncated to the low Z_WIDTH bits.
  - Flags are sampled together with valid_i.
- Pipeline: expected value and valid flag pass through a LATENCY-deep shift register. In RUN and DRAIN, an operand pair accepted at cycle N is compared against z_i at the rising edge of cycle N+LATENCY.
- Valid_i is captured into the pipeline only in RUN. Each pipeline slot with valid=1 produces exactly one comparison.
- Comparison:
  - Uses the 4-state inequality z_i !== expected, so X or Z bits on z_i count as errors (simulation).
  - On each comparison, chk_count_o increments.
  - On a mismatch, err_count_o also increments and fail_o is set.
- Counters saturate at all-ones; no wrap-around.
- Counter and fail_o updates are registered and appear one cycle after the compare edge.
- done_o asserts the cycle after the last valid slot leaves the pipeline in DRAIN. If stop_i arrives with the pipeline empty, DRAIN lasts exactly 1 cycle.
- A reset during RUN or DRAIN discards in-flight entries; none are counted.

Optional Feature:
- DSP_CHK_FIRST_ERR_EN.
- When defined, adds three output ports:
  - first_err_exp_o, Z_WIDTH, expected value of the first mismatch.
  - first_err_got_o, Z_WIDTH, z_i value of the first mismatch.
  - first_err_idx_o, CNT_WIDTH, chk_count value at which the first mismatch occurred.
- These ports are captured only on the first mismatch after start_i and cleared by reset and by start_i.
- When the macro is undefined, the ports and their registers do not exist.

Test Plan:
- LATENCY=1, signed:
  - Stimulus: A=-3, B=7 → z_i=-21 one cycle later. Then A=20'h7FFFF, B=18'h1FFFF with the correct z_i.
  - Response: chk_count=2, err_count=0, fail_o=0.
- Unsigned flags: A=20'hFFFFF, B=2 with unsigned_a=1.
  - Required expected: 38'h1FFFFE. Driving z_i=-2 → err_count=1, fail_o=1.
- LATENCY=2 alignment:
  - Stimulus: 10 back-to-back operand pairs, z_i delayed by 2 cycles.
  - Response: 10 checks, 0 errors. The same stream with z_i delayed by only 1 cycle → errors greater than 0.
- Stop/drain:
  - Stimulus: stop_i in the cycle after the last valid, LATENCY=2.
  - Response: done_o rises after the final compare, chk_count equals the number of valids, operands arriving after stop_i are not counted.
- Saturation and restart:
  - Stimulus: CNT_WIDTH=4, 20 mismatches.
  - Response: err_count=15. A following start_i clears the counters to 0 and fail_o to 0.
- Async reset mid-run:
  - Stimulus: reset_n_i low for half a cycle with 2 entries in flight.
  - Response: all outputs 0 immediately, state IDLE, no further counts.
